exam_job_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for one shared multi-cycle exam compute engine (operands a/b/c/d in, results g/h out, level start/done handshake, active-low engine reset). Grants one requester at a time, latches its operands, clears the engine, drives start until done, and returns the results tagged with the requester ID. An optional watchdog aborts jobs whose engine never asserts done.

---
 rtl/exam_job_arbiter.sv | 145 ++++++++++++++
 tb/tb_exam_job_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/exam_job_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle exam engine between two requesters.
// Define ARB_WATCHDOG_EN to abort jobs whose engine never raises done within TIMEOUT cycles.
module exam_job_arbiter #(
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic [4*W-1:0] op0,
  input  logic [4*W-1:0] op1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           busy,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_g,
  output logic [W-1:0]   rsp_h,
  output logic           rsp_timeout,
  output logic [W-1:0]   eng_a,
  output logic [W-1:0]   eng_b,
  output logic [W-1:0]   eng_c,
  output logic [W-1:0]   eng_d,
  output logic           eng_start,
  output logic           eng_rst_n,
  input  logic [W-1:0]   eng_g,
  input  logic [W-1:0]   eng_h,
  input  logic           eng_done
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StResp} state_e;

  state_e         state_q;
  logic           last_q;
  logic           sel_q;
  logic           pick;
  logic [4*W-1:0] op_pick;

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
  logic [CntW-1:0] cnt_q;
  logic            expired;
  assign expired = (cnt_q == CntMax);
`endif

  // On contention the requester not served last wins; otherwise the sole requester.
  always_comb begin
    pick    = (req0 && req1) ? ~last_q : req1;
    op_pick = pick ? op1 : op0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_g       <= '0;
      rsp_h       <= '0;
      rsp_timeout <= 1'b0;
      eng_a       <= '0;
      eng_b       <= '0;
      eng_c       <= '0;
      eng_d       <= '0;
      eng_start   <= 1'b0;
      eng_rst_n   <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      cnt_q       <= '0;
`endif
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          eng_rst_n <= 1'b1;
          if (req0 || req1) begin
            state_q   <= StClear;
            sel_q     <= pick;
            gnt0      <= ~pick;
            gnt1      <= pick;
            busy      <= 1'b1;
            eng_rst_n <= 1'b0;
            eng_start <= 1'b0;
            eng_a     <= op_pick[4*W-1:3*W];
            eng_b     <= op_pick[3*W-1:2*W];
            eng_c     <= op_pick[2*W-1:W];
            eng_d     <= op_pick[W-1:0];
`ifdef ARB_WATCHDOG_EN
            cnt_q     <= '0;
`endif
          end
        end
        StClear: begin
          state_q   <= StRun;
          eng_rst_n <= 1'b1;
          eng_start <= 1'b1;
`ifdef ARB_WATCHDOG_EN
          cnt_q     <= '0;
`endif
        end
        StRun: begin
`ifdef ARB_WATCHDOG_EN
          cnt_q <= cnt_q + 1'b1;
`endif
          // Done takes priority over a coincident watchdog expiry.
          if (eng_done) begin
            state_q     <= StResp;
            last_q      <= sel_q;
            rsp_valid   <= 1'b1;
            rsp_id      <= sel_q;
            rsp_g       <= eng_g;
            rsp_h       <= eng_h;
            rsp_timeout <= 1'b0;
            eng_start   <= 1'b0;
          end
`ifdef ARB_WATCHDOG_EN
          else if (expired) begin
            state_q     <= StResp;
            last_q      <= sel_q;
            rsp_valid   <= 1'b1;
            rsp_id      <= sel_q;
            rsp_g       <= '0;
            rsp_h       <= '0;
            rsp_timeout <= 1'b1;
            eng_start   <= 1'b0;
          end
`endif
        end
        StResp: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exam_job_arbiter.sv
// Directed bench for exam_job_arbiter; watchdog steps are compiled in only with ARB_WATCHDOG_EN.
module tb_exam_job_arbiter;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, req1;
  logic [4*W-1:0] op0, op1;
  logic           gnt0, gnt1, busy, rsp_valid, rsp_id, rsp_timeout;
  logic [W-1:0]   rsp_g, rsp_h, eng_a, eng_b, eng_c, eng_d, eng_g, eng_h;
  logic           eng_start, eng_rst_n, eng_done;
  logic           exp_id;

  int n_cmp = 0;
  int n_err = 0;

  exam_job_arbiter #(.W(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_g(rsp_g), .rsp_h(rsp_h), .rsp_timeout(rsp_timeout),
    .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c), .eng_d(eng_d),
    .eng_start(eng_start), .eng_rst_n(eng_rst_n),
    .eng_g(eng_g), .eng_h(eng_h), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {gnt0, gnt1, busy, rsp_valid, rsp_timeout, eng_start, eng_rst_n}, 7'b0);
    chk({tag, "_id"}, rsp_id, 1'b0);
    chk({tag, "_rsp"}, {rsp_g, rsp_h}, 32'h0);
    chk({tag, "_ops"}, {eng_a, eng_b, eng_c, eng_d}, 64'h0);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
    eng_done = 1'b0; eng_g = '0; eng_h = '0;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();
    chk("rst_release_eng_rst_n", eng_rst_n, 1'b1);

    // Single job, operand isolation folded in; cycle 0 is this IDLE cycle.
    req0 = 1'b1;
    op0  = {16'd2, 16'd3, 16'd4, 16'd5};
    tick();
    chk("job_gnt", {gnt0, gnt1, busy, eng_rst_n}, 4'b1010);
    chk("job_ops", {eng_a, eng_b, eng_c, eng_d}, 64'h0002_0003_0004_0005);
    req0 = 1'b0;
    tick();
    chk("job_run", {gnt0, eng_start, eng_rst_n}, 3'b011);
    op0 = '1;
    for (int k = 3; k <= 7; k++) begin
      tick();
      chk("job_wait", {rsp_valid, eng_start}, 2'b01);
    end
    eng_done = 1'b1; eng_g = 16'h0040; eng_h = 16'h0003;
    tick();
    chk("job_rsp", {rsp_valid, rsp_id, rsp_timeout, eng_start, busy}, 5'b10001);
    chk("job_rsp_data", {rsp_g, rsp_h}, 32'h0040_0003);
    chk("job_iso_ops", {eng_a, eng_b, eng_c, eng_d}, 64'h0002_0003_0004_0005);
    eng_done = 1'b0; eng_g = 16'hdead; eng_h = 16'hbeef;
    tick();
    chk("job_idle", {rsp_valid, busy}, 2'b00);
    chk("job_hold", {rsp_g, rsp_h}, 32'h0040_0003);

    // Contention from reset: serve order 0,1,0,1.
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    op0 = 64'h1111_2222_3333_4444;
    op1 = 64'h5555_6666_7777_8888;
    tick();
    chk_reset("cont_rst");
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      exp_id = j[0];
      tick();
      chk("cont_gnt", {gnt0, gnt1, busy}, exp_id ? 3'b011 : 3'b101);
      chk("cont_ops", {eng_a, eng_b, eng_c, eng_d}, exp_id ? op1 : op0);
      tick();
      chk("cont_run", {eng_start, busy}, 2'b11);
      eng_done = 1'b1; eng_g = 16'(j + 1); eng_h = 16'(100 + j);
      tick();
      chk("cont_rsp", {rsp_valid, rsp_id, busy}, {1'b1, exp_id, 1'b1});
      chk("cont_rsp_data", {rsp_g, rsp_h}, {16'(j + 1), 16'(100 + j)});
      eng_done = 1'b0;
      if (j == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
      chk("cont_idle", {busy, gnt0, gnt1}, 3'b000);
    end

    // Engine that never finishes.
    req1 = 1'b1;
    tick();
    chk("wd_gnt", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0;
    tick();
`ifdef ARB_WATCHDOG_EN
    for (int k = 3; k <= 9; k++) begin
      tick();
      chk("wd_wait", rsp_valid, 1'b0);
    end
    tick();
    chk("wd_rsp", {rsp_valid, rsp_id, rsp_timeout}, 3'b111);
    chk("wd_rsp_data", {rsp_g, rsp_h}, 32'h0);
    tick();
    req0 = 1'b1;
    tick();
    chk("wd_next_gnt", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    tick();
    for (int k = 3; k <= 9; k++) begin
      tick();
      chk("wd_edge_wait", rsp_valid, 1'b0);
    end
    eng_done = 1'b1; eng_g = 16'h1234; eng_h = 16'h5678;
    tick();
    chk("wd_edge_rsp", {rsp_valid, rsp_id, rsp_timeout}, 3'b100);
    chk("wd_edge_data", {rsp_g, rsp_h}, 32'h1234_5678);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("nowd_wait", {rsp_valid, eng_start, busy}, 3'b011);
    end
    eng_done = 1'b1; eng_g = 16'h1234; eng_h = 16'h5678;
    tick();
    chk("nowd_rsp", {rsp_valid, rsp_id, rsp_timeout}, 3'b110);
    chk("nowd_data", {rsp_g, rsp_h}, 32'h1234_5678);
`endif
    eng_done = 1'b0;
    tick();

    // Reset during RUN, then a fresh job from requester 1.
    req1 = 1'b1;
    op1  = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    req1 = 1'b0;
    tick();
    tick();
    chk("mid_run", eng_start, 1'b1);
    rst = 1'b1;
    tick();
    chk_reset("mid_rst");
    rst = 1'b0;
    eng_done = 1'b1;
    tick();
    chk("mid_after", {rsp_valid, busy, eng_rst_n}, 3'b001);
    eng_done = 1'b0;
    req1 = 1'b1;
    tick();
    chk("mid_gnt", {gnt0, gnt1}, 2'b01);
    chk("mid_ops", {eng_a, eng_b, eng_c, eng_d}, 64'hAAAA_BBBB_CCCC_DDDD);
    req1 = 1'b0;
    tick();
    eng_done = 1'b1; eng_g = 16'h0f0f; eng_h = 16'hf0f0;
    tick();
    chk("mid_rsp", {rsp_valid, rsp_id, rsp_timeout}, 3'b110);
    chk("mid_rsp_data", {rsp_g, rsp_h}, 32'h0f0f_f0f0);
    eng_done = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
